matrix_mul_engine: RTL and testbench

//  Sequential single-precision (IEEE-754 binary32) matrix multiplier: C = A x B, A is MxK, B is KxN.

---
 rtl/matrix_mul_engine_if.sv | 20 ++
 rtl/matrix_mul_engine.sv | 196 +++++++++++++++++++
 tb/tb_matrix_mul_engine.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mul_engine_if.sv
// Start/done handshake plus flat operand/result word arrays of the matrix multiplier.
interface matrix_mul_engine_if #(
   parameter int MAX_M = 100,
   parameter int MAX_K = 100,
   parameter int MAX_N = 100
);
   logic [7:0]  M_val;
   logic [7:0]  K_val;
   logic [7:0]  N_val;
   logic        start;
   logic        done;
   logic [31:0] matrix_A [MAX_M*MAX_K];
   logic [31:0] matrix_B [MAX_K*MAX_N];
   logic [31:0] matrix_C [MAX_M*MAX_N];

   modport master (output M_val, K_val, N_val, start, matrix_A, matrix_B,
                   input  done, matrix_C);
   modport slave  (input  M_val, K_val, N_val, start, matrix_A, matrix_B,
                   output done, matrix_C);
endinterface

// File: rtl/matrix_mul_engine.sv
// Sequential binary32 C = A x B, one multiply-accumulate per clock (RNE, flush-to-zero).
// done rises M*N*(K+1) edges after the start edge; start is ignored while busy.
module matrix_mul_engine #(
   parameter int MAX_M = 100,
   parameter int MAX_K = 100,
   parameter int MAX_N = 100
) (
   input logic                clk,
   input logic                rst_n,
   matrix_mul_engine_if.slave bus
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam int AAW = $clog2(MAX_M*MAX_K);
   localparam int BAW = $clog2(MAX_K*MAX_N);
   localparam int CAW = $clog2(MAX_M*MAX_N);

   typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

   state_t         state_q, state_d;
   logic [7:0]     md_q, md_d, kd_q, kd_d, nd_q, nd_d;
   logic [7:0]     i_q, i_d, j_q, j_d, kk_q, kk_d;
   logic [31:0]    acc_q, acc_d, mac_res;
   logic           done_q, c_we;
   logic [7:0]     m_lat, k_lat, n_lat;
   logic [AAW-1:0] a_idx;
   logic [BAW-1:0] b_idx;
   logic [CAW-1:0] c_idx;

   // Round a 24-bit significand with guard/sticky, then apply overflow and flush-to-zero.
   function automatic logic [31:0] fp_round(input logic s, input int e, input logic [23:0] m,
                                            input logic g, input logic st);
      logic [24:0] r;
      int          ee;
      r  = {1'b0, m} + {24'd0, g & (st | m[0])};
      ee = e;
      if (r[24]) begin
         r  = r >> 1;
         ee = ee + 1;
      end
      if (ee >= 255)    fp_round = {s, 8'hFF, 23'd0};
      else if (ee <= 0) fp_round = {s, 31'd0};
      else              fp_round = {s, ee[7:0], r[22:0]};
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, za, zb, ia, ib, na, nb;
      logic [47:0] p;
      int          e;
      s  = a[31] ^ b[31];
      za = (a[30:23] == 8'd0);
      zb = (b[30:23] == 8'd0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) e = e + 1;
      else       p = p << 1;
      if (na || nb || (ia && zb) || (ib && za)) fp_mul = QNAN;
      else if (ia || ib)                        fp_mul = {s, 8'hFF, 23'd0};
      else if (za || zb)                        fp_mul = {s, 31'd0};
      else fp_mul = fp_round(s, e, p[47:24], p[23], |p[22:0]);
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic        za, zb, ia, ib, na, nb;
      logic [26:0] mx, my, sh;
      logic [27:0] sum;
      int          e, d;
      za = (a[30:23] == 8'd0);
      zb = (b[30:23] == 8'd0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (na || nb || (ia && ib && (a[31] != b[31]))) fp_add = QNAN;
      else if (ia)       fp_add = {a[31], 8'hFF, 23'd0};
      else if (ib)       fp_add = {b[31], 8'hFF, 23'd0};
      else if (za && zb) fp_add = {a[31] & b[31], 31'd0};
      else if (za)       fp_add = b;
      else if (zb)       fp_add = a;
      else begin
         if (a[30:0] >= b[30:0]) begin x = a; y = b; end
         else                    begin x = b; y = a; end
         mx = {1'b1, x[22:0], 3'd0};
         my = {1'b1, y[22:0], 3'd0};
         d  = int'(x[30:23]) - int'(y[30:23]);
         // Shifted-out bits collapse into the sticky LSB of the aligned operand.
         if (d >= 27) sh = 27'd1;
         else begin
            sh = my >> d;
            if ((my & ~(27'h7FF_FFFF << d)) != 27'd0) sh[0] = 1'b1;
         end
         e = int'(x[30:23]);
         if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, sh};
            if (sum[27]) begin
               sum = {1'b0, sum[27:1]} | {27'd0, sum[0]};
               e   = e + 1;
            end
         end else begin
            sum = {1'b0, mx} - {1'b0, sh};
            for (int p = 0; p < 27; p++) begin
               if (!sum[26] && (sum != 28'd0)) begin
                  sum = sum << 1;
                  e   = e - 1;
               end
            end
         end
         if (sum == 28'd0) fp_add = 32'd0;
         else fp_add = fp_round(x[31], e, sum[26:3], sum[2], |sum[1:0]);
      end
   endfunction

   assign m_lat   = (bus.M_val > 8'(MAX_M)) ? 8'(MAX_M) : bus.M_val;
   assign k_lat   = (bus.K_val > 8'(MAX_K)) ? 8'(MAX_K) : bus.K_val;
   assign n_lat   = (bus.N_val > 8'(MAX_N)) ? 8'(MAX_N) : bus.N_val;
   assign a_idx   = AAW'(i_q) * AAW'(kd_q) + AAW'(kk_q);
   assign b_idx   = BAW'(kk_q) * BAW'(nd_q) + BAW'(j_q);
   assign c_idx   = CAW'(i_q) * CAW'(nd_q) + CAW'(j_q);
   assign mac_res = fp_add(acc_q, fp_mul(bus.matrix_A[a_idx], bus.matrix_B[b_idx]));
   assign bus.done = done_q;

   always_comb begin
      state_d = state_q;
      md_d    = md_q;
      kd_d    = kd_q;
      nd_d    = nd_q;
      i_d     = i_q;
      j_d     = j_q;
      kk_d    = kk_q;
      acc_d   = acc_q;
      c_we    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               md_d    = m_lat;
               kd_d    = k_lat;
               nd_d    = n_lat;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kk_d    = 8'd0;
               acc_d   = 32'd0;
               state_d = ((m_lat == 8'd0) || (k_lat == 8'd0) || (n_lat == 8'd0)) ? DONE : MAC;
            end
         end
         MAC: begin
            acc_d = mac_res;
            if (kk_q == kd_q - 8'd1) state_d = STORE;
            else                     kk_d    = kk_q + 8'd1;
         end
         STORE: begin
            c_we    = 1'b1;
            acc_d   = 32'd0;
            kk_d    = 8'd0;
            state_d = MAC;
            if (j_q == nd_q - 8'd1) begin
               j_d = 8'd0;
               if (i_q == md_q - 8'd1) state_d = DONE;
               else                    i_d     = i_q + 8'd1;
            end else begin
               j_d = j_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         md_q    <= 8'd0;
         kd_q    <= 8'd0;
         nd_q    <= 8'd0;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         kk_q    <= 8'd0;
         acc_q   <= 32'd0;
         done_q  <= 1'b0;
         for (int w = 0; w < MAX_M*MAX_N; w++) bus.matrix_C[w] <= 32'd0;
      end else begin
         state_q <= state_d;
         md_q    <= md_d;
         kd_q    <= kd_d;
         nd_q    <= nd_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kk_q    <= kk_d;
         acc_q   <= acc_d;
         done_q  <= (state_d == DONE);
         if (c_we) bus.matrix_C[c_idx] <= acc_q;
      end
   end
endmodule

// File: tb/tb_matrix_mul_engine.sv
// Scoreboard bench: double-precision reference rounded to binary32 RNE/FTZ, C words compared after done.
module tb_matrix_mul_engine;
   localparam int MX    = 10;
   localparam int LIMIT = 5000;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] a_mem   [MX*MX];
   logic [31:0] b_mem   [MX*MX];
   logic [31:0] c_model [MX*MX];
   logic [31:0] exp_q   [$];

   matrix_mul_engine_if #(.MAX_M(MX), .MAX_K(MX), .MAX_N(MX)) bus ();

   matrix_mul_engine #(.MAX_M(MX), .MAX_K(MX), .MAX_N(MX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic real f2d(input logic [31:0] f);
      logic [63:0] b;
      logic [10:0] e;
      if (f[30:23] == 8'd0) b = {f[31], 63'd0};
      else if (f[30:23] == 8'hFF)
         b = (f[22:0] != 23'd0) ? 64'h7FF8_0000_0000_0000 : {f[31], 11'h7FF, 52'd0};
      else begin
         e = 11'(int'(f[30:23]) + 896);
         b = {f[31], e, f[22:0], 29'd0};
      end
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] d2f(input real r);
      logic [63:0] b;
      logic [24:0] rm;
      logic [28:0] rest;
      int          fe;
      b = $realtobits(r);
      if (b[62:52] == 11'h7FF) return (b[51:0] != 52'd0) ? QNAN : {b[63], 8'hFF, 23'd0};
      if (b[62:52] == 11'd0) return {b[63], 31'd0};
      fe   = int'(b[62:52]) - 896;
      rm   = {2'b01, b[51:29]};
      rest = b[28:0];
      if ((rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && rm[0])) rm = rm + 25'd1;
      if (rm[24]) begin
         rm = rm >> 1;
         fe = fe + 1;
      end
      if (fe >= 255) return {b[63], 8'hFF, 23'd0};
      if (fe <= 0)   return {b[63], 31'd0};
      return {b[63], fe[7:0], rm[22:0]};
   endfunction

   function automatic logic [31:0] fmodel_mul(input logic [31:0] a, input logic [31:0] b);
      return d2f(f2d(a) * f2d(b));
   endfunction

   function automatic logic [31:0] fmodel_add(input logic [31:0] a, input logic [31:0] b);
      return d2f(f2d(a) + f2d(b));
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      int          e;
      r = $urandom;
      e = $urandom_range(130, 120);
      return {r[31], e[7:0], r[15:0], 7'd0};
   endfunction

   task automatic fill_random();
      for (int w = 0; w < MX*MX; w++) begin
         a_mem[w] = rnd_op();
         b_mem[w] = rnd_op();
      end
   endtask

   task automatic check_all_c(input string tag);
      for (int w = 0; w < MX*MX; w++)
         check_eq($sformatf("%s_c%0d", tag, w), bus.matrix_C[w], exp_q.pop_front());
   endtask

   task automatic run_mm(input int m, input int k, input int n, input bit busy_pulse,
                         input string tag);
      int          mc, kc, nc, lat, exp_lat;
      logic [31:0] acc;
      mc = (m > MX) ? MX : m;
      kc = (k > MX) ? MX : k;
      nc = (n > MX) ? MX : n;
      for (int w = 0; w < MX*MX; w++) begin
         bus.matrix_A[w] = a_mem[w];
         bus.matrix_B[w] = b_mem[w];
      end
      exp_lat = 0;
      if ((mc != 0) && (kc != 0) && (nc != 0)) begin
         for (int i = 0; i < mc; i++)
            for (int j = 0; j < nc; j++) begin
               acc = 32'd0;
               for (int kk = 0; kk < kc; kk++)
                  acc = fmodel_add(acc, fmodel_mul(a_mem[i*kc+kk], b_mem[kk*nc+j]));
               c_model[i*nc+j] = acc;
            end
         exp_lat = mc * nc * (kc + 1);
      end
      for (int w = 0; w < MX*MX; w++) exp_q.push_back(c_model[w]);
      bus.M_val = 8'(m);
      bus.K_val = 8'(k);
      bus.N_val = 8'(n);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && (lat < LIMIT)) begin
         bus.start = (busy_pulse && (lat == 3)) ? 1'b1 : 1'b0;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check_eq({tag, "_lat"}, lat, exp_lat);
      repeat (2) @(negedge clk);
      check_eq({tag, "_hold"}, {31'd0, bus.done}, 32'd1);
      check_all_c(tag);
   endtask

   initial begin
      int m, k, n;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.M_val = 8'd0;
      bus.K_val = 8'd0;
      bus.N_val = 8'd0;
      for (int w = 0; w < MX*MX; w++) begin
         a_mem[w] = 32'd0; b_mem[w] = 32'd0; c_model[w] = 32'd0;
         bus.matrix_A[w] = 32'd0; bus.matrix_B[w] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_done", {31'd0, bus.done}, 32'd0);
      for (int w = 0; w < MX*MX; w++) exp_q.push_back(32'd0);
      check_all_c("rst");
      rst_n = 1'b1;
      @(negedge clk);

      a_mem[0] = 32'h3F80_0000; a_mem[1] = 32'h4000_0000;
      a_mem[2] = 32'h4040_0000; a_mem[3] = 32'h4080_0000;
      for (int w = 0; w < 4; w++) b_mem[w] = a_mem[w];
      run_mm(2, 2, 2, 1'b0, "m222");
      check_eq("m222_lit0", bus.matrix_C[0], 32'h40E0_0000);
      check_eq("m222_lit1", bus.matrix_C[1], 32'h4120_0000);
      check_eq("m222_lit2", bus.matrix_C[2], 32'h4170_0000);
      check_eq("m222_lit3", bus.matrix_C[3], 32'h41B0_0000);

      a_mem[0] = 32'h3F80_0000; a_mem[1] = 32'hBF80_0000;
      b_mem[0] = 32'h3F80_0000; b_mem[1] = 32'h3F80_0000;
      run_mm(1, 2, 1, 1'b0, "cancel");
      check_eq("cancel_lit", bus.matrix_C[0], 32'h0000_0000);

      fill_random();
      for (int i = 0; i < 3; i++)
         for (int kk = 0; kk < 3; kk++) a_mem[i*3+kk] = (i == kk) ? 32'h3F80_0000 : 32'd0;
      run_mm(3, 3, 3, 1'b0, "ident");
      for (int w = 0; w < 9; w++) check_eq($sformatf("ident_b%0d", w), bus.matrix_C[w], b_mem[w]);

      for (int t = 0; t < 4; t++) begin
         fill_random();
         m = $urandom_range(MX, 2);
         k = $urandom_range(MX, 2);
         n = $urandom_range(MX, 2);
         run_mm(m, k, n, (t == 1), $sformatf("rnd%0d", t));
      end

      fill_random();
      run_mm(200, 3, 255, 1'b0, "clamp");

      run_mm(4, 0, 4, 1'b0, "k0");

      fill_random();
      for (int w = 0; w < MX*MX; w++) begin
         bus.matrix_A[w] = a_mem[w];
         bus.matrix_B[w] = b_mem[w];
      end
      bus.M_val = 8'd4; bus.K_val = 8'd4; bus.N_val = 8'd4;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
      for (int w = 0; w < MX*MX; w++) begin
         c_model[w] = 32'd0;
         exp_q.push_back(32'd0);
      end
      check_all_c("midrst");
      rst_n = 1'b1;
      @(negedge clk);
      run_mm(3, 5, 4, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
